// File: rtl/barrel_shift_pipe_if.sv
// Valid/ready stream bundle for barrel_shift_pipe: operand issue side plus result side.
// The master modport drives operands and out_ready; the slave modport is the shifter itself.
interface barrel_shift_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;
   logic             busy;

   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_zero, busy
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_zero, busy
   );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Fully pipelined barrel shifter/rotator: one register rank per amount bit, each rank
// carrying its own op/amt/tag, with per-rank valid/ready so bubbles collapse under stalls.
module barrel_shift_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   barrel_shift_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   logic [SHW:0]     valid_q;
   logic [SHW:0]     ready;
   logic [WIDTH-1:0] data_q    [SHW+1];
   logic [TAG_W-1:0] tag_q     [SHW+1];
   logic [SHW-1:0]   amt_q     [SHW];
   logic [2:0]       op_q      [SHW];
   logic [WIDTH-1:0] stage_out [1:SHW];

   // The MSB of an SRA operand never changes from rank to rank, so it doubles as the fill bit.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input logic [2:0] op, input int s);
      case (op)
         OP_SLL:  shift_by = d << s;
         OP_SRL:  shift_by = d >> s;
         OP_SRA:  shift_by = $unsigned($signed(d) >>> s);
         OP_ROL:  shift_by = (d << s) | (d >> (WIDTH - s));
         OP_ROR:  shift_by = (d >> s) | (d << (WIDTH - s));
         default: shift_by = d;
      endcase
   endfunction

   always_comb begin
      ready = '0;
      ready[SHW] = ~valid_q[SHW] | bus.out_ready;
      for (int k = SHW - 1; k >= 0; k--) begin
         ready[k] = ~valid_q[k] | ready[k+1];
      end
   end

   always_comb begin
      for (int k = 1; k <= SHW; k++) begin
         stage_out[k] = amt_q[k-1][k-1] ? shift_by(data_q[k-1], op_q[k-1], 1 << (k-1))
                                        : data_q[k-1];
      end
   end

   // A ready rank either is empty or is handing its beat on, so it always takes whatever
   // the rank behind offers (including a bubble).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k <= SHW; k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
         end
         for (int k = 0; k < SHW; k++) begin
            amt_q[k] <= '0;
            op_q[k]  <= '0;
         end
      end else begin
         if (ready[0]) begin
            valid_q[0] <= bus.in_valid;
         end
         if (bus.in_valid && ready[0]) begin
            data_q[0] <= bus.in_data;
            tag_q[0]  <= bus.in_tag;
            amt_q[0]  <= bus.in_amt;
            op_q[0]   <= bus.in_op;
         end
         for (int k = 1; k <= SHW; k++) begin
            if (ready[k]) begin
               valid_q[k] <= valid_q[k-1];
            end
            if (valid_q[k-1] && ready[k]) begin
               data_q[k] <= stage_out[k];
               tag_q[k]  <= tag_q[k-1];
            end
         end
         for (int k = 1; k < SHW; k++) begin
            if (valid_q[k-1] && ready[k]) begin
               amt_q[k] <= amt_q[k-1];
               op_q[k]  <= op_q[k-1];
            end
         end
      end
   end

   assign bus.in_ready  = ready[0];
   assign bus.out_valid = valid_q[SHW];
   assign bus.out_data  = data_q[SHW];
   assign bus.out_tag   = tag_q[SHW];
   assign bus.out_zero  = ~|data_q[SHW];
   assign bus.busy      = |valid_q;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed vectors, backpressure, bubble collapse,
// random traffic against a whole-amount shift model, mid-stream reset and an 8-bit instance.
module tb_barrel_shift_pipe;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   barrel_shift_pipe_if #(.WIDTH(32), .TAG_W(4)) wbus ();
   barrel_shift_pipe_if #(.WIDTH(8),  .TAG_W(4)) nbus ();

   barrel_shift_pipe #(.WIDTH(32), .TAG_W(4)) dut        (.clk(clk), .rst_n(rst_n), .bus(wbus));
   barrel_shift_pipe #(.WIDTH(8),  .TAG_W(4)) dut_narrow (.clk(clk), .rst_n(rst_n), .bus(nbus));

   int          checks = 0;
   int          passes = 0;
   int          acc    = 0;
   int          rem    = 0;
   int          cycle  = 0;
   bit          last_in_ready;
   bit          last_out_valid;
   logic [35:0] exp_q[$];
   int          rem_cycles[$];

   // Whole-amount reference: rotates come from a doubled operand instead of staged shifts.
   function automatic logic [31:0] model(input logic [2:0] op, input int amt, input logic [31:0] d);
      logic [63:0] dd;
      dd = {d, d};
      case (op)
         3'd0:    return d << amt;
         3'd1:    return d >> amt;
         3'd2:    return 32'($signed(d) >>> amt);
         3'd3:    begin dd = dd << amt; return dd[63:32]; end
         3'd4:    begin dd = dd >> amt; return dd[31:0]; end
         default: return d;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
   endtask

   // One clock of traffic on the 32-bit instance, scoreboarded; entered and left at posedge+1.
   task automatic apply_stimulus(input bit iv, input logic [2:0] op, input logic [4:0] amt,
                                 input logic [31:0] d, input logic [3:0] tag, input bit orr,
                                 output bit accepted);
      int          occ;
      logic [35:0] e;
      wbus.in_valid  = iv;
      wbus.in_op     = op;
      wbus.in_amt    = amt;
      wbus.in_data   = d;
      wbus.in_tag    = tag;
      wbus.out_ready = orr;
      @(negedge clk);
      occ            = acc - rem;
      last_in_ready  = wbus.in_ready;
      last_out_valid = wbus.out_valid;
      check_output("in_ready", 64'(wbus.in_ready), 64'(orr || occ < 6));
      check_output("busy", 64'(wbus.busy), 64'(occ != 0));
      if (wbus.out_valid && orr) begin
         check_output("pending_beat", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_output("out_data", 64'(wbus.out_data), 64'(e[31:0]));
            check_output("out_tag", 64'(wbus.out_tag), 64'(e[35:32]));
            check_output("out_zero", 64'(wbus.out_zero), 64'(e[31:0] == 32'h0));
         end
         rem++;
         rem_cycles.push_back(cycle);
      end
      accepted = iv && wbus.in_ready;
      if (accepted) begin
         exp_q.push_back({tag, model(op, int'(amt), d)});
         acc++;
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Single beat into an empty pipe: checks latency, data, tag, zero flag and drain.
   task automatic run_single(input string name, input bit narrow, input logic [2:0] op, input int amt,
                             input logic [31:0] d, input logic [3:0] tag, input logic [31:0] exp_data);
      int j;
      wbus.out_ready = 1'b1;
      nbus.out_ready = 1'b1;
      if (narrow) begin
         nbus.in_valid = 1'b1; nbus.in_op = op; nbus.in_amt = 3'(amt);
         nbus.in_data  = d[7:0]; nbus.in_tag = tag;
      end else begin
         wbus.in_valid = 1'b1; wbus.in_op = op; wbus.in_amt = 5'(amt);
         wbus.in_data  = d; wbus.in_tag = tag;
      end
      @(negedge clk);
      check_output({name, "_in_ready"}, narrow ? 64'(nbus.in_ready) : 64'(wbus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      wbus.in_valid = 1'b0;
      nbus.in_valid = 1'b0;
      j = 0;
      while (!(narrow ? nbus.out_valid : wbus.out_valid) && j < 20) begin
         @(posedge clk);
         #1;
         j++;
      end
      check_output({name, "_latency"}, 64'(j + 1), narrow ? 64'(4) : 64'(6));
      check_output({name, "_data"}, narrow ? 64'(nbus.out_data) : 64'(wbus.out_data), 64'(exp_data));
      check_output({name, "_tag"}, narrow ? 64'(nbus.out_tag) : 64'(wbus.out_tag), 64'(tag));
      check_output({name, "_zero"}, narrow ? 64'(nbus.out_zero) : 64'(wbus.out_zero), 64'(exp_data == 0));
      @(posedge clk);
      #1;
      check_output({name, "_drained"}, narrow ? 64'(nbus.busy) : 64'(wbus.busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc_flag;
      bit orr;
      bit trig;
      bit saw_low;
      int sent;
      int stall;
      int c0;

      wbus.in_valid = 1'b0; wbus.in_data = '0; wbus.in_amt = '0; wbus.in_op = '0; wbus.in_tag = '0;
      wbus.out_ready = 1'b1;
      nbus.in_valid = 1'b0; nbus.in_data = '0; nbus.in_amt = '0; nbus.in_op = '0; nbus.in_tag = '0;
      nbus.out_ready = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check_output("rst_out_valid", 64'(wbus.out_valid), 64'(0));
      check_output("rst_out_data", 64'(wbus.out_data), 64'(0));
      check_output("rst_out_tag", 64'(wbus.out_tag), 64'(0));
      check_output("rst_out_zero", 64'(wbus.out_zero), 64'(1));
      check_output("rst_busy", 64'(wbus.busy), 64'(0));
      check_output("rst_in_ready", 64'(wbus.in_ready), 64'(1));
      check_output("rst_n_out_valid", 64'(nbus.out_valid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_single("sll31", 1'b0, 3'd0, 31, 32'h0000_0001, 4'h1, 32'h8000_0000);
      run_single("srl4",  1'b0, 3'd1,  4, 32'h8000_0000, 4'h2, 32'h0800_0000);
      run_single("sra4",  1'b0, 3'd2,  4, 32'h8000_0000, 4'h3, 32'hF800_0000);
      run_single("sra31", 1'b0, 3'd2, 31, 32'h7FFF_FFFF, 4'h4, 32'h0000_0000);
      run_single("rol1",  1'b0, 3'd3,  1, 32'h8000_0001, 4'h5, 32'h0000_0003);
      run_single("ror1",  1'b0, 3'd4,  1, 32'h8000_0001, 4'h6, 32'hC000_0000);
      run_single("rol16", 1'b0, 3'd3, 16, 32'h1234_5678, 4'h7, 32'h5678_1234);
      run_single("pass7", 1'b0, 3'd7,  5, 32'hDEAD_BEEF, 4'h8, 32'hDEAD_BEEF);
      run_single("n_ror7", 1'b1, 3'd4, 7, 32'h01, 4'h9, 32'h02);
      run_single("n_sra7", 1'b1, 3'd2, 7, 32'h80, 4'hA, 32'hFF);

      // Backpressure: ten back-to-back beats, output stalled eight cycles once tag 0 shows up.
      acc = 0; rem = 0; exp_q.delete(); rem_cycles.delete();
      sent = 0; trig = 1'b0; stall = 8; saw_low = 1'b0;
      for (int c = 0; c < 200 && rem < 10; c++) begin
         if (!trig && wbus.out_valid) trig = 1'b1;
         orr = 1'b1;
         if (trig && stall > 0) begin
            orr = 1'b0;
            stall--;
         end
         apply_stimulus(sent < 10, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom,
                        4'(sent), orr, acc_flag);
         if (acc_flag) sent++;
         if (!last_in_ready) saw_low = 1'b1;
         if (trig && orr) check_output("bp_back_to_back", 64'(last_out_valid), 64'(1));
      end
      check_output("bp_in_ready_dropped", 64'(saw_low), 64'(1));
      check_output("bp_received", 64'(rem), 64'(10));
      check_output("bp_leftover", 64'(exp_q.size()), 64'(0));

      // Bubble collapse: the second beat should close up behind the stalled first one.
      acc = 0; rem = 0; exp_q.delete(); rem_cycles.delete();
      c0 = cycle;
      for (int c = 0; c < 40 && rem < 2; c++) begin
         apply_stimulus(c == 0 || c == 3, 3'd3, 5'(c + 1), $urandom, (c == 0) ? 4'hA : 4'hB,
                        c < 5 || c >= 12, acc_flag);
      end
      check_output("bubble_received", 64'(rem), 64'(2));
      if (rem_cycles.size() >= 2) begin
         check_output("bubble_first_exit", 64'(rem_cycles[0] - c0), 64'(12));
         check_output("bubble_gap", 64'(rem_cycles[1] - rem_cycles[0]), 64'(1));
      end

      // Random traffic with random backpressure, then drain.
      acc = 0; rem = 0; exp_q.delete(); rem_cycles.delete();
      for (int c = 0; c < 400; c++) begin
         apply_stimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                        $urandom, 4'($urandom), $urandom_range(0, 9) < 7, acc_flag);
      end
      for (int c = 0; c < 40 && acc != rem; c++) begin
         apply_stimulus(1'b0, 3'd0, 5'd0, 32'h0, 4'h0, 1'b1, acc_flag);
      end
      check_output("rnd_drained", 64'(acc - rem), 64'(0));
      check_output("rnd_leftover", 64'(exp_q.size()), 64'(0));

      // Reset mid-cycle with four beats in flight.
      acc = 0; rem = 0; exp_q.delete();
      for (int c = 0; c < 4; c++) begin
         apply_stimulus(1'b1, 3'd0, 5'(c), $urandom, 4'(c), 1'b1, acc_flag);
      end
      for (int c = 0; c < 10 && !wbus.out_valid; c++) begin
         apply_stimulus(1'b0, 3'd0, 5'd0, 32'h0, 4'h0, 1'b1, acc_flag);
      end
      check_output("mid_out_valid_before", 64'(wbus.out_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_out_valid", 64'(wbus.out_valid), 64'(0));
      check_output("mid_rst_busy", 64'(wbus.busy), 64'(0));
      check_output("mid_rst_out_data", 64'(wbus.out_data), 64'(0));
      check_output("mid_rst_out_zero", 64'(wbus.out_zero), 64'(1));
      wbus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("mid_rst_held_busy", 64'(wbus.busy), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      acc = 0; rem = 0; exp_q.delete();
      run_single("post_rst_sll3", 1'b0, 3'd0, 3, 32'h0000_0001, 4'hC, 32'h0000_0008);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
Parametrised, fully pipelined barrel shifter/rotator with valid/ready flow control. It supports logical-left, logical-right, arithmetic-right, rotate-left and rotate-right.
- Shift amount, op and a user tag travel with the data through every stage, so each beat carries its own control.
- Each stage can stall independently and empty stages fill up (bubbles collapse).
- It sits between operand-issue logic and the writeback/result mux of the datapath.

Parameters:
WIDTH, 32, data width; power of 2, >= 4.
TAG_W, 4, width of the user tag carried alongside each beat; >= 1.
(derived localparam) SHW = log2(WIDTH), shift-amount width and number of shift stages.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  WIDTH  operand.
in_amt  input  SHW  shift amount, 0..WIDTH-1.
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
in_tag  input  TAG_W  opaque tag, returned unchanged.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  WIDTH  result.
out_tag  output  TAG_W  tag of the result beat.
out_zero  output  1  out_data == 0.
busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately clears every stage valid bit and every data, tag, amt and op register to 0.
  - Outputs during reset: out_valid=0, out_data=0, out_tag=0, out_zero=1, busy=0, in_ready=1.
  - Beats in flight are discarded. Operation resumes on the first rising clk after rst_n deasserts.
- Pipeline has SHW+1 register ranks:
  - Rank 0 captures the input (data, amt, op, tag).
  - Rank k (1..SHW) holds the result after applying bit k-1 of amt, i.e. a shift by 2^(k-1).
  - Rank SHW drives the outputs directly (registered outputs).
- Latency with no backpressure: a beat accepted at edge N appears on out_valid after edge N+SHW. That is SHW+1 cycles, 6 for WIDTH=32.
- Throughput is one beat per clock.
- Per-rank handshake:
  - advance[SHW] = valid[SHW] & out_ready.
  - ready[k] = ~valid[k] | advance[k]. Rank k loads from rank k-1 when valid[k-1] & ready[k].
  - in_ready = ready[0]. A beat is accepted when in_valid & in_ready.
- A rank that is not loading holds its contents. Bubbles collapse: an empty rank accepts even if the next rank is stalled.
- Input acceptance and output removal in the same cycle are legal.
- in_ready is combinational from out_ready through the ready chain. It is 0 only when every rank from 0 up to the first empty rank is full and out_ready=0.
- Per-stage operation, with amt bit b and s = 2^b:
  - Bit clear: pass the data through.
  - SLL: data << s, zero fill.
  - SRL: data >> s, zero fill.
  - SRA: data >> s, fill with data[WIDTH-1] of the original operand. The sign is invariant across stages.
  - ROL: rotate left by s.
  - ROR: rotate right by s.
  - Pass-through op codes: data unchanged regardless of amt.
- amt=0 leaves data unchanged for every op.
- amt and op in each rank are those of the beat in that rank, never live inputs.
- out_zero is computed combinationally from the registered out_data.
- busy = OR of all rank valid bits.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated under any out_ready pattern.
- Input signals are ignored when in_valid=0. Inputs are undefined-tolerant while in_ready=0.

Test Plan:
SLL / SRL / SRA, WIDTH=32:
- SLL 0x00000001 amt=31 -> 0x80000000 exactly 6 cycles after acceptance.
- SRL 0x80000000 amt=4 -> 0x08000000.
- SRA 0x80000000 amt=4 -> 0xF8000000.
- SRA 0x7FFFFFFF amt=31 -> 0x00000000 with out_zero=1.

Rotates and pass-through:
- ROL 0x80000001 amt=1 -> 0x00000003.
- ROR 0x80000001 amt=1 -> 0xC0000000.
- ROL 0x12345678 amt=16 -> 0x56781234.
- op=111 amt=5 on 0xDEADBEEF -> 0xDEADBEEF.

Backpressure:
- Stimulus: 10 back-to-back beats with tags 0..9; out_ready low for 8 cycles starting once tag 0 is at the output.
- Required: in_ready drops to 0 once all 6 ranks are full.
- Required: all 10 results arrive in tag order with correct data, with no loss or duplication.
- Required: after out_ready returns high, one result per cycle.

Bubble collapse:
- Stimulus: beats at cycles 0 and 3, out_ready=0 from cycle 5.
- Required: the second beat advances until it sits directly behind the first.
- Required: in_ready stays 1 while rank 0 is empty.

Reset mid-stream:
- Stimulus: assert rst_n=0 mid-clock-cycle with 4 beats in flight.
- Required: out_valid=0 and busy=0 immediately, without waiting for a clock edge.
- Required: after release, a fresh SLL 0x1 amt=3 returns 0x8 with latency 6 and no stale beats.

Narrow instance (WIDTH=8, SHW=3):
- ROR 0x01 amt=7 -> 0x02.
- SRA 0x80 amt=7 -> 0xFF.
- Latency is 4 cycles.
